// File: rtl/cache_perf_counter.sv
// I-cache / D-cache access and miss counters with saturation, sticky overflow,
// atomic snapshot/clear, and a one-outstanding read port serving the shadow copies.
module cache_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             icache_valid_i,
    input  logic             icache_miss_i,
    input  logic             dcache_valid_i,
    input  logic             dcache_miss_i,
    input  logic             snap_i,
    input  logic             clr_i,
    input  logic             rd_valid_i,
    output logic             rd_ready_o,
    input  logic [2:0]       rd_addr_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [CNT_W-1:0] rsp_data_o,
    output logic             rsp_err_o
);

    typedef enum logic {StIdle, StResp} state_e;

    // Index order IA, IM, DA, DM matches the overflow bit order.
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [CNT_W-1:0] sh_q  [4];
    logic [3:0]       ov_q, ov_d, shov_q;
    logic [3:0]       ev;

    state_e           state_q;
    logic [CNT_W-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic [CNT_W-1:0] rd_data;
    logic             rd_err;

    assign ev = {dcache_valid_i & dcache_miss_i, dcache_valid_i,
                 icache_valid_i & icache_miss_i, icache_valid_i};

    always_comb begin
        ov_d = ov_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_i) begin
                cnt_d[i] = '0;
                ov_d[i]  = 1'b0;
            end else if (en_i && ev[i]) begin
                if (&cnt_q[i]) begin
                    ov_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Shadows capture pre-update live values, so snap+clr keeps the old counts.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
                sh_q[i]  <= '0;
            end
            ov_q   <= '0;
            shov_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (snap_i) begin
                    sh_q[i] <= cnt_q[i];
                end
            end
            ov_q <= ov_d;
            if (snap_i) begin
                shov_q <= ov_q;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_addr_i)
            3'd0:    rd_data = sh_q[0];
            3'd1:    rd_data = sh_q[1];
            3'd2:    rd_data = sh_q[2];
            3'd3:    rd_data = sh_q[3];
            3'd4:    rd_data = CNT_W'(shov_q);
            default: rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rd_valid_i) begin
                        rsp_data_q <= rd_data;
                        rsp_err_q  <= rd_err;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rd_ready_o  = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
